// File: rtl/code_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module : code_v2_pkg
// Brief  : State encoding and quarter-index constants for the I2C write master
// Rev    : 1.0  initial release
// ============================================================================
package code_v2_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ADDR  = 3'd2,
      S_ACK1  = 3'd3,
      S_DATA  = 3'd4,
      S_ACK2  = 3'd5,
      S_STOP  = 3'd6
   } state_t;

   localparam logic [1:0] c_Q0 = 2'd0;
   localparam logic [1:0] c_Q1 = 2'd1;
   localparam logic [1:0] c_Q2 = 2'd2;
   localparam logic [1:0] c_Q3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/i2c_qtick.sv
`default_nettype none
// ============================================================================
// Module : i2c_qtick
// Brief  : Divider producing the SCL quarter strobe and 2-bit quarter index
// Rev    : 1.0  initial release
// ============================================================================
module i2c_qtick
   import code_v2_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   output logic       o_tick,
   output logic [1:0] o_qidx
);

   localparam int              c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(CLK_DIV - 1);

   logic [c_DW-1:0] r_div;
   logic [1:0]      r_q;

   // Held at zero while disabled so every transfer starts on a clean q0.
   always_ff @(posedge clk) begin
      if (!rst_n || !i_en) begin
         r_div <= '0;
         r_q   <= c_Q0;
      end else if (r_div == c_DIV_MAX) begin
         r_div <= '0;
         r_q   <= r_q + 2'd1;
      end else begin
         r_div <= r_div + c_DW'(1);
      end
   end

   assign o_tick = i_en && (r_div == c_DIV_MAX);
   assign o_qidx = r_q;

endmodule
`default_nettype wire

// File: rtl/code_v2.sv
`default_nettype none
// ============================================================================
// Module : code_v2
// Brief  : Self-triggered I2C single-write master (START, addr, ACK, data, ACK, STOP)
// Rev    : 1.0  initial release
// ============================================================================
module code_v2
   import code_v2_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   inout  wire        SDA,
   output logic       SCL,
   input  logic [7:0] Address,
   input  logic [7:0] Data,
   output logic       BUSY,
   output logic       ACK_ERR
);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_addr;
   logic [7:0]  r_data;
   logic [15:0] r_last;
   logic [2:0]  r_bit;
   logic        r_nack;
   logic        r_ack_err;

   logic        w_tick;
   logic [1:0]  w_q;
   logic        w_trig;
   logic        w_last_q;
   logic        w_sample;
   logic        w_cur_bit;
   logic        w_sda_low;
   logic        w_scl;

   i2c_qtick #(
      .CLK_DIV (CLK_DIV)
   ) u_qtick (
      .clk    (CLK),
      .rst_n  (RST_N),
      .i_en   (r_state != S_IDLE),
      .o_tick (w_tick),
      .o_qidx (w_q)
   );

   assign w_trig   = ({Address, Data} != r_last);
   assign w_last_q = w_tick && (w_q == c_Q3);
   assign w_sample = w_tick && (w_q == c_Q2);

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_sda_low = 1'b0;
      w_scl     = 1'b1;
      w_cur_bit = (r_state == S_DATA) ? r_data[r_bit] : r_addr[r_bit];
      case (r_state)
         S_IDLE: begin
            if (w_trig) w_next = S_START;
         end
         S_START: begin
            w_sda_low = (w_q != c_Q0);
            w_scl     = (w_q != c_Q3);
            if (w_last_q) w_next = S_ADDR;
         end
         S_ADDR, S_DATA: begin
            w_sda_low = ~w_cur_bit;
            w_scl     = (w_q == c_Q1) || (w_q == c_Q2);
            if (w_last_q && (r_bit == 3'd0))
               w_next = (r_state == S_ADDR) ? S_ACK1 : S_ACK2;
         end
         S_ACK1: begin
            w_scl = (w_q == c_Q1) || (w_q == c_Q2);
            if (w_last_q) w_next = r_nack ? S_STOP : S_DATA;
         end
         S_ACK2: begin
            w_scl = (w_q == c_Q1) || (w_q == c_Q2);
            if (w_last_q) w_next = S_STOP;
         end
         S_STOP: begin
            w_sda_low = (w_q == c_Q0) || (w_q == c_Q1);
            w_scl     = (w_q != c_Q0);
            if (w_last_q) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The ACK bit is captured on the last cycle of q2 so the q3 decision sees it registered.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_addr    <= 8'h00;
         r_data    <= 8'h00;
         r_last    <= 16'h0000;
         r_bit     <= 3'd0;
         r_nack    <= 1'b0;
         r_ack_err <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_trig) begin
            r_addr    <= Address;
            r_data    <= Data;
            r_last    <= {Address, Data};
            r_nack    <= 1'b0;
            r_ack_err <= 1'b0;
         end
         if (w_last_q) begin
            if ((r_state == S_START) || (r_state == S_ACK1))
               r_bit <= 3'd7;
            else if ((r_state == S_ADDR) || (r_state == S_DATA))
               r_bit <= r_bit - 3'd1;
         end
         if (w_sample && ((r_state == S_ACK1) || (r_state == S_ACK2))) begin
            r_nack <= SDA;
            if (SDA) r_ack_err <= 1'b1;
         end
      end
   end

   assign SDA     = w_sda_low ? 1'b0 : 1'bz;
   assign SCL     = w_scl;
   assign BUSY    = (r_state != S_IDLE);
   assign ACK_ERR = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_code_v2.sv
`default_nettype none
// ============================================================================
// Module : tb_code_v2
// Brief  : Directed self-checking bench for the code_v2 I2C write master
// Rev    : 1.0  initial release
// ============================================================================
module tb_code_v2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] data = 8'h00;
   logic       scl;
   logic       busy;
   logic       ack_err;
   wire        sda;

   bit         slave_en = 1'b0;
   bit         ack_drive = 1'b0;

   int         n_checks = 0;
   int         n_pass = 0;

   int         n_start = 0;
   int         n_stop = 0;
   logic [7:0] byte_log[$];
   logic       ack_log[$];

   pullup (sda);
   assign sda = ack_drive ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   code_v2 #(.CLK_DIV(4)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .SDA     (sda),
      .SCL     (scl),
      .Address (address),
      .Data    (data),
      .BUSY    (busy),
      .ACK_ERR (ack_err)
   );

   // Bus monitor and slave: decodes START/STOP, shifts bytes on SCL rise, pulls ACK when enabled.
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;
   int         bitcnt = 0;
   logic [7:0] sh = 8'h00;

   always @(negedge clk) begin
      if (p_scl && scl && p_sda && !sda) begin
         n_start++;
         bitcnt = 0;
      end else if (p_scl && scl && !p_sda && sda) begin
         n_stop++;
         bitcnt = 0;
      end else if (!p_scl && scl) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], sda};
            bitcnt++;
            if (bitcnt == 8) byte_log.push_back(sh);
         end else begin
            ack_log.push_back(sda);
            bitcnt = 0;
         end
      end else if (p_scl && !scl) begin
         if (bitcnt == 8 && slave_en) ack_drive = 1'b1;
         else if (bitcnt == 0)        ack_drive = 1'b0;
      end
      p_scl = scl;
      p_sda = sda;
   end

   // Waits for BUSY to rise, then counts BUSY-high cycles; optionally changes Data mid-transfer.
   task automatic wait_xfer(input int chg_at, input logic [7:0] chg_val,
                            output int cycles, output bit ok, output logic err0);
      ok     = 1'b0;
      cycles = 0;
      err0   = 1'bx;
      for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
      if (!busy) return;
      err0 = ack_err;
      while (busy && cycles < 2000) begin
         cycles++;
         if (chg_at != 0 && cycles == chg_at) data = chg_val;
         @(negedge clk);
      end
      ok = !busy;
   endtask

   task automatic test_reset;
      bit bad = 1'b0;
      int s0;
      rst_n   = 1'b0;
      address = 8'h00;
      data    = 8'h00;
      @(negedge clk);
      s0 = n_start;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) bad = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", ack_err);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) bad = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (bad !== 1'b0) $display("FAIL idle_lines: bus or busy moved, flag %b want 0", bad);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
      else n_pass++;
      n_checks++;
      if (n_start - s0 !== 0) $display("FAIL idle_starts: got %0d want 0", n_start - s0);
      else n_pass++;
   endtask

   task automatic test_ack;
      int cyc, s0, p0, b0, a0;
      bit ok;
      logic e0;
      s0 = n_start; p0 = n_stop; b0 = byte_log.size(); a0 = ack_log.size();
      slave_en = 1'b1;
      address  = 8'h33;
      data     = 8'hF0;
      wait_xfer(0, 8'h00, cyc, ok, e0);
      n_checks++;
      if (!ok) $display("FAIL ack_timeout: busy never completed, cycles %0d", cyc);
      else n_pass++;
      n_checks++;
      if (cyc !== 320) $display("FAIL ack_busy_len: got %0d want 320", cyc);
      else n_pass++;
      n_checks++;
      if (ack_err !== 1'b0) $display("FAIL ack_err: got %b want 0", ack_err);
      else n_pass++;
      n_checks++;
      if (n_start - s0 !== 1 || n_stop - p0 !== 1)
         $display("FAIL ack_start_stop: got %0d/%0d want 1/1", n_start - s0, n_stop - p0);
      else n_pass++;
      n_checks++;
      if (byte_log.size() - b0 !== 2) $display("FAIL ack_nbytes: got %0d want 2", byte_log.size() - b0);
      else if (byte_log[b0] !== 8'h33 || byte_log[b0+1] !== 8'hF0)
         $display("FAIL ack_bytes: got %h %h want 33 f0", byte_log[b0], byte_log[b0+1]);
      else n_pass++;
      n_checks++;
      if (ack_log.size() - a0 !== 2) $display("FAIL ack_nslots: got %0d want 2", ack_log.size() - a0);
      else if (ack_log[a0] !== 1'b0 || ack_log[a0+1] !== 1'b0)
         $display("FAIL ack_slots: got %b %b want 0 0", ack_log[a0], ack_log[a0+1]);
      else n_pass++;
      n_checks++;
      if (scl !== 1'b1 || sda !== 1'b1) $display("FAIL ack_release: scl %b sda %b want 1 1", scl, sda);
      else n_pass++;
   endtask

   task automatic test_nack;
      int cyc, s0, p0, b0, a0;
      bit ok;
      logic e0;
      slave_en = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      s0 = n_start; p0 = n_stop; b0 = byte_log.size(); a0 = ack_log.size();
      rst_n = 1'b1;
      wait_xfer(0, 8'h00, cyc, ok, e0);
      n_checks++;
      if (!ok || cyc !== 176) $display("FAIL nack_busy_len: got %0d (done %b) want 176", cyc, ok);
      else n_pass++;
      n_checks++;
      if (ack_err !== 1'b1) $display("FAIL nack_err: got %b want 1", ack_err);
      else n_pass++;
      n_checks++;
      if (n_start - s0 !== 1 || n_stop - p0 !== 1)
         $display("FAIL nack_start_stop: got %0d/%0d want 1/1", n_start - s0, n_stop - p0);
      else n_pass++;
      n_checks++;
      if (byte_log.size() - b0 !== 1 || byte_log[b0] !== 8'h33)
         $display("FAIL nack_bytes: got %0d bytes first %h want 1 byte 33", byte_log.size() - b0, byte_log[b0]);
      else n_pass++;
      n_checks++;
      if (ack_log.size() - a0 !== 1 || ack_log[a0] !== 1'b1)
         $display("FAIL nack_slot: got %0d slots first %b want 1 slot 1", ack_log.size() - a0, ack_log[a0]);
      else n_pass++;
   endtask

   task automatic test_mid_change;
      int cyc, s0, b0, a0;
      bit ok;
      logic e0;
      slave_en = 1'b0;
      rst_n    = 1'b0;
      address  = 8'h33;
      data     = 8'hF0;
      @(negedge clk);
      s0 = n_start; b0 = byte_log.size(); a0 = ack_log.size();
      rst_n = 1'b1;
      wait_xfer(50, 8'h0F, cyc, ok, e0);
      n_checks++;
      if (!ok || cyc !== 176) $display("FAIL mid_first_len: got %0d (done %b) want 176", cyc, ok);
      else n_pass++;
      n_checks++;
      if (ack_err !== 1'b1) $display("FAIL mid_first_err: got %b want 1", ack_err);
      else n_pass++;
      slave_en = 1'b1;
      wait_xfer(0, 8'h00, cyc, ok, e0);
      n_checks++;
      if (e0 !== 1'b0) $display("FAIL mid_err_clear: got %b want 0 at second start", e0);
      else n_pass++;
      n_checks++;
      if (!ok || cyc !== 320) $display("FAIL mid_second_len: got %0d (done %b) want 320", cyc, ok);
      else n_pass++;
      n_checks++;
      if (byte_log.size() - b0 !== 3) $display("FAIL mid_nbytes: got %0d want 3", byte_log.size() - b0);
      else if (byte_log[b0] !== 8'h33 || byte_log[b0+1] !== 8'h33 || byte_log[b0+2] !== 8'h0F)
         $display("FAIL mid_bytes: got %h %h %h want 33 33 0f", byte_log[b0], byte_log[b0+1], byte_log[b0+2]);
      else n_pass++;
      n_checks++;
      if (ack_log.size() - a0 !== 3 || ack_log[a0+1] !== 1'b0 || ack_log[a0+2] !== 1'b0)
         $display("FAIL mid_slots: got %0d slots want 3 with last two 0", ack_log.size() - a0);
      else n_pass++;
      n_checks++;
      if (n_start - s0 !== 2) $display("FAIL mid_starts: got %0d want 2", n_start - s0);
      else n_pass++;
      n_checks++;
      if (ack_err !== 1'b0) $display("FAIL mid_final_err: got %b want 0", ack_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int cyc, b0, a0;
      bit ok;
      logic e0;
      slave_en = 1'b1;
      address  = 8'h33;
      data     = 8'hF0;
      for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
      // Offset 229 after the first busy sample lands in DATA bit 3, quarter 1 (SCL high).
      repeat (229) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || scl !== 1'b1 || sda !== 1'b0)
         $display("FAIL rmid_bit3: busy %b scl %b sda %b want 1 1 0", busy, scl, sda);
      else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1)
         $display("FAIL rmid_release: busy %b scl %b sda %b want 0 1 1", busy, scl, sda);
      else n_pass++;
      n_checks++;
      if (ack_err !== 1'b0) $display("FAIL rmid_err: got %b want 0", ack_err);
      else n_pass++;
      b0 = byte_log.size(); a0 = ack_log.size();
      rst_n = 1'b1;
      wait_xfer(0, 8'h00, cyc, ok, e0);
      n_checks++;
      if (!ok || cyc !== 320) $display("FAIL rmid_len: got %0d (done %b) want 320", cyc, ok);
      else n_pass++;
      n_checks++;
      if (byte_log.size() - b0 !== 2) $display("FAIL rmid_nbytes: got %0d want 2", byte_log.size() - b0);
      else if (byte_log[b0] !== 8'h33 || byte_log[b0+1] !== 8'hF0)
         $display("FAIL rmid_bytes: got %h %h want 33 f0", byte_log[b0], byte_log[b0+1]);
      else n_pass++;
      n_checks++;
      if (ack_log.size() - a0 !== 2 || ack_err !== 1'b0)
         $display("FAIL rmid_acks: got %0d slots err %b want 2 slots err 0", ack_log.size() - a0, ack_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ack();
      test_nack();
      test_mid_change();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
